chrono_ctrl: RTL and testbench

Run/stop/lap controller for the chronometer BCD counter chain. Converts two debounced push-button levels into a four-state control FSM, generates the prescaled count-enable tick and synchronous clear for the four-digit counter, and captures lap values. Also time-multiplexes the live or lap digits onto a four-digit common-anode seven-segment display, upstream of the segment decoder.

---
 rtl/chrono_ctrl.sv | 149 ++++++++++++++
 tb/tb_chrono_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chrono_ctrl.sv
// Run/stop/lap control FSM for the chronometer counter chain, with tick prescaler,
// lap capture and four-digit multiplexed display scan.
module chrono_ctrl #(
    parameter int unsigned TICK_DIV = 5_000_000,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] counter_0,
    input  logic [3:0] counter_1,
    input  logic [3:0] counter_2,
    input  logic [3:0] counter_3,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic [3:0] disp_digit,
    output logic [3:0] disp_an,
    output logic [1:0] state
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10,
        ST_LAP  = 2'b11
    } state_e;

    state_e        state_q;
    logic          ss_prev_q, lr_prev_q;
    logic          ss_press_q, lr_press_q;
    logic          ss_press_d, lr_press_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, clr_q;
    logic          counting, pre_wrap;
    logic [3:0]    lap_q [4];
    logic [3:0]    live [4];
    logic [3:0]    src_digit;
    logic [SW-1:0] scan_q, scan_d;
    logic          scan_wrap;
    logic [1:0]    idx_q;
    logic [3:0]    an_q, digit_q;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        ss_press_d = btn_ss & ~ss_prev_q;
        lr_press_d = btn_lr & ~lr_prev_q & ~ss_press_d;

        counting = (state_q == ST_RUN) || (state_q == ST_LAP);
        pre_wrap = counting && (pre_q == PW'(TICK_DIV - 1));
        pre_d    = pre_q;
        if (counting) begin
            pre_d = pre_wrap ? '0 : pre_q + PW'(1);
        end

        scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + SW'(1);

        live[0]   = counter_0;
        live[1]   = counter_1;
        live[2]   = counter_2;
        live[3]   = counter_3;
        src_digit = (state_q == ST_LAP) ? lap_q[idx_q] : live[idx_q];
    end

    // NOTE: sequential state uses non-blocking assignments only; the lap registers are
    // reset as well because the display reads them straight after reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            ss_prev_q  <= 1'b1;
            lr_prev_q  <= 1'b1;
            ss_press_q <= 1'b0;
            lr_press_q <= 1'b0;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            clr_q      <= 1'b0;
            for (int i = 0; i < 4; i++) lap_q[i] <= 4'd0;
            scan_q     <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1110;
            digit_q    <= 4'd0;
        end else begin
            ss_prev_q  <= btn_ss;
            lr_prev_q  <= btn_lr;
            ss_press_q <= ss_press_d;
            lr_press_q <= lr_press_d;
            pre_q      <= pre_d;
            tick_q     <= pre_wrap;
            clr_q      <= 1'b0;

            // A clear only happens in IDLE/STOP, where the prescaler is not counting,
            // so clearing it here can never collide with a tick.
            case (state_q)
                ST_IDLE: begin
                    if (ss_press_q) begin
                        state_q <= ST_RUN;
                    end else if (lr_press_q) begin
                        clr_q <= 1'b1;
                        pre_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (ss_press_q) begin
                        state_q <= ST_STOP;
                    end else if (lr_press_q) begin
                        lap_q[0] <= counter_0;
                        lap_q[1] <= counter_1;
                        lap_q[2] <= counter_2;
                        lap_q[3] <= counter_3;
                        state_q  <= ST_LAP;
                    end
                end
                ST_STOP: begin
                    if (ss_press_q) begin
                        state_q <= ST_RUN;
                    end else if (lr_press_q) begin
                        clr_q   <= 1'b1;
                        pre_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_LAP: begin
                    if (ss_press_q) begin
                        state_q <= ST_STOP;
                    end else if (lr_press_q) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            scan_q <= scan_d;
            if (scan_wrap) idx_q <= idx_q + 2'd1;
            an_q    <= ~(4'b0001 << idx_q);
            digit_q <= src_digit;
        end
    end

    assign cnt_tick   = tick_q;
    assign cnt_clr    = clr_q;
    assign disp_digit = digit_q;
    assign disp_an    = an_q;
    assign state      = state_q;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Self-checking bench for chrono_ctrl: directed scenarios plus randomized button and
// counter activity, all compared every cycle against a behavioural model.
module tb_chrono_ctrl;

    localparam int TD  = 4;
    localparam int SD  = 2;
    localparam int SD3 = 3;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STOP = 2'b10;
    localparam logic [1:0] S_LAP  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss, btn_lr;
    logic [3:0] cnt [4];
    logic       cnt_tick, cnt_clr;
    logic [3:0] disp_digit, disp_an;
    logic [1:0] state;

    logic       zero_ss = 1'b0, zero_lr = 1'b0;
    logic [3:0] scnt [4];
    logic       s_tick, s_clr;
    logic [3:0] s_digit, s_an;
    logic [1:0] s_state;

    always #5 clk = ~clk;

    chrono_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) u_dut (
        .CLK(clk), .RST(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .counter_0(cnt[0]), .counter_1(cnt[1]), .counter_2(cnt[2]), .counter_3(cnt[3]),
        .cnt_tick(cnt_tick), .cnt_clr(cnt_clr),
        .disp_digit(disp_digit), .disp_an(disp_an), .state(state)
    );

    chrono_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD3)) u_scan (
        .CLK(clk), .RST(rst), .btn_ss(zero_ss), .btn_lr(zero_lr),
        .counter_0(scnt[0]), .counter_1(scnt[1]), .counter_2(scnt[2]), .counter_3(scnt[3]),
        .cnt_tick(s_tick), .cnt_clr(s_clr),
        .disp_digit(s_digit), .disp_an(s_an), .state(s_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: button edges become pending events one cycle later; the
    // prescaler phase is the number of counting cycles since the last clear.
    logic [1:0] m_state;
    logic       m_ss_prev, m_lr_prev, m_ss_ev, m_lr_ev;
    logic       m_tick, m_clr;
    logic [3:0] m_lap [4];
    logic [3:0] m_an, m_digit, m_san, m_sdigit;
    int         m_run;
    int         m_k;
    int         g_cyc = 0;
    int         tick_log[$];

    task automatic step();
        int         idx_m, idx_s;
        logic [1:0] nxt;
        logic       ss_n, lr_n;
        @(posedge clk);
        g_cyc++;
        if (!rst) begin
            m_state = S_IDLE; m_ss_prev = 1'b1; m_lr_prev = 1'b1;
            m_ss_ev = 1'b0; m_lr_ev = 1'b0; m_tick = 1'b0; m_clr = 1'b0;
            for (int i = 0; i < 4; i++) m_lap[i] = 4'd0;
            m_an = 4'b1110; m_digit = 4'd0; m_san = 4'b1110; m_sdigit = 4'd0;
            m_run = 0; m_k = 0;
        end else begin
            idx_m = (m_k / SD) % 4;
            idx_s = (m_k / SD3) % 4;
            m_k++;
            m_an     = ~(4'b0001 << idx_m);
            m_digit  = (m_state == S_LAP) ? m_lap[idx_m] : cnt[idx_m];
            m_san    = ~(4'b0001 << idx_s);
            m_sdigit = scnt[idx_s];
            m_tick = 1'b0;
            m_clr  = 1'b0;
            if (m_state == S_RUN || m_state == S_LAP) begin
                m_run++;
                m_tick = (m_run % TD) == 0;
            end
            nxt = m_state;
            if (m_ss_ev) begin
                nxt = (m_state == S_RUN || m_state == S_LAP) ? S_STOP : S_RUN;
            end else if (m_lr_ev) begin
                case (m_state)
                    S_IDLE: m_clr = 1'b1;
                    S_RUN: begin
                        for (int i = 0; i < 4; i++) m_lap[i] = cnt[i];
                        nxt = S_LAP;
                    end
                    S_STOP: begin m_clr = 1'b1; nxt = S_IDLE; end
                    default: nxt = S_RUN;
                endcase
            end
            if (m_clr) m_run = 0;
            m_state = nxt;
            ss_n = btn_ss && !m_ss_prev;
            lr_n = btn_lr && !m_lr_prev && !ss_n;
            m_ss_ev = ss_n; m_lr_ev = lr_n;
            m_ss_prev = btn_ss; m_lr_prev = btn_lr;
        end
        @(negedge clk);
        n_cmp++;
        if (state !== m_state) begin
            n_bad++; $display("FAIL state @%0d: got %b expected %b", g_cyc, state, m_state);
        end
        n_cmp++;
        if (cnt_tick !== m_tick) begin
            n_bad++; $display("FAIL cnt_tick @%0d: got %b expected %b", g_cyc, cnt_tick, m_tick);
        end
        n_cmp++;
        if (cnt_clr !== m_clr) begin
            n_bad++; $display("FAIL cnt_clr @%0d: got %b expected %b", g_cyc, cnt_clr, m_clr);
        end
        n_cmp++;
        if (disp_an !== m_an) begin
            n_bad++; $display("FAIL disp_an @%0d: got %b expected %b", g_cyc, disp_an, m_an);
        end
        n_cmp++;
        if (disp_digit !== m_digit) begin
            n_bad++; $display("FAIL disp_digit @%0d: got %0d expected %0d", g_cyc, disp_digit, m_digit);
        end
        n_cmp++;
        if (s_an !== m_san) begin
            n_bad++; $display("FAIL scan3_an @%0d: got %b expected %b", g_cyc, s_an, m_san);
        end
        n_cmp++;
        if (s_digit !== m_sdigit) begin
            n_bad++; $display("FAIL scan3_digit @%0d: got %0d expected %0d", g_cyc, s_digit, m_sdigit);
        end
        if (cnt_tick) tick_log.push_back(g_cyc);
    endtask

    task automatic press_ss();
        btn_ss = 1'b1; step();
        btn_ss = 1'b0; step();
    endtask

    task automatic press_lr();
        btn_lr = 1'b1; step();
        btn_lr = 1'b0; step();
    endtask

    task automatic set_cnt(input int d0, input int d1, input int d2, input int d3);
        cnt[0] = 4'(d0); cnt[1] = 4'(d1); cnt[2] = 4'(d2); cnt[3] = 4'(d3);
    endtask

    task automatic test_reset();
        rst = 1'b0; btn_ss = 1'b1;
        step(); step();
        n_cmp++;
        if (state !== S_IDLE || disp_an !== 4'b1110 || cnt_tick !== 1'b0 || cnt_clr !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: got state=%b an=%b tick=%b clr=%b expected 00 1110 0 0",
                     state, disp_an, cnt_tick, cnt_clr);
        end
        rst = 1'b1;
        repeat (10) step();
        n_cmp++;
        if (state !== S_IDLE) begin
            n_bad++; $display("FAIL held_button_no_run: got state=%b expected 00", state);
        end
        btn_ss = 1'b0;
        step();
    endtask

    task automatic test_run_stop();
        int start_n;
        press_ss();
        tick_log.delete();
        repeat (38) step();
        press_ss();
        n_cmp++;
        if (tick_log.size() != 10) begin
            n_bad++; $display("FAIL run_tick_count: got %0d expected 10", tick_log.size());
        end
        for (int i = 1; i < tick_log.size(); i++) begin
            n_cmp++;
            if (tick_log[i] - tick_log[i-1] != TD) begin
                n_bad++;
                $display("FAIL tick_spacing[%0d]: got %0d expected %0d", i, tick_log[i] - tick_log[i-1], TD);
            end
        end
        n_cmp++;
        if (state !== S_STOP) begin
            n_bad++; $display("FAIL run_to_stop: got %b expected 10", state);
        end
        start_n = tick_log.size();
        repeat (12) step();
        n_cmp++;
        if (tick_log.size() != start_n) begin
            n_bad++; $display("FAIL stop_no_tick: got %0d ticks expected 0", tick_log.size() - start_n);
        end
        press_ss();
        repeat (7) step();
    endtask

    task automatic test_lap();
        logic [3:0] oh;
        int         lapv [4];
        int         livev [4];
        int         start_n;
        lapv  = '{3, 2, 1, 0};
        livev = '{9, 9, 5, 9};
        set_cnt(3, 2, 1, 0);
        step();
        press_lr();
        n_cmp++;
        if (state !== S_LAP) begin
            n_bad++; $display("FAIL lap_enter: got %b expected 11", state);
        end
        set_cnt(9, 9, 5, 9);
        start_n = tick_log.size();
        repeat (12) begin
            step();
            for (int i = 0; i < 4; i++) begin
                oh = 4'b0001 << i;
                if (disp_an == ~oh) begin
                    n_cmp++;
                    if (disp_digit !== 4'(lapv[i])) begin
                        n_bad++; $display("FAIL lap_hold[%0d]: got %0d expected %0d", i, disp_digit, lapv[i]);
                    end
                end
            end
        end
        n_cmp++;
        if (tick_log.size() - start_n != 3) begin
            n_bad++; $display("FAIL lap_tick_continues: got %0d expected 3", tick_log.size() - start_n);
        end
        press_lr();
        n_cmp++;
        if (state !== S_RUN) begin
            n_bad++; $display("FAIL lap_exit: got %b expected 01", state);
        end
        step();
        repeat (8) begin
            step();
            for (int i = 0; i < 4; i++) begin
                oh = 4'b0001 << i;
                if (disp_an == ~oh) begin
                    n_cmp++;
                    if (disp_digit !== 4'(livev[i])) begin
                        n_bad++; $display("FAIL live_after_lap[%0d]: got %0d expected %0d", i, disp_digit, livev[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_clear();
        int waited;
        press_ss();
        repeat (3) step();
        press_lr();
        n_cmp++;
        if (cnt_clr !== 1'b1 || cnt_tick !== 1'b0 || state !== S_IDLE) begin
            n_bad++;
            $display("FAIL clear_pulse: got clr=%b tick=%b state=%b expected 1 0 00", cnt_clr, cnt_tick, state);
        end
        step();
        n_cmp++;
        if (cnt_clr !== 1'b0) begin
            n_bad++; $display("FAIL clear_single_cycle: got %b expected 0", cnt_clr);
        end
        press_ss();
        waited = 0;
        do begin
            step();
            waited++;
        end while (!cnt_tick && waited < 20);
        n_cmp++;
        if (waited != TD) begin
            n_bad++; $display("FAIL first_tick_after_clear: got %0d cycles expected %0d", waited, TD);
        end
    endtask

    task automatic test_simultaneous();
        n_cmp++;
        if (state !== S_RUN) begin
            n_bad++; $display("FAIL simul_precondition: got %b expected 01", state);
        end
        btn_ss = 1'b1; btn_lr = 1'b1; step();
        btn_ss = 1'b0; btn_lr = 1'b0; step();
        n_cmp++;
        if (state !== S_STOP || cnt_clr !== 1'b0) begin
            n_bad++; $display("FAIL simultaneous: got state=%b clr=%b expected 10 0", state, cnt_clr);
        end
        repeat (4) step();
    endtask

    task automatic test_scan();
        int         changes;
        logic [3:0] prev;
        prev    = s_an;
        changes = 0;
        repeat (24) begin
            step();
            if (s_an !== prev) changes++;
            prev = s_an;
        end
        n_cmp++;
        if (changes != 8) begin
            n_bad++; $display("FAIL scan3_changes: got %0d expected 8", changes);
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            if ($urandom_range(3) == 0) btn_ss = ~btn_ss;
            if ($urandom_range(3) == 0) btn_lr = ~btn_lr;
            for (int i = 0; i < 4; i++) cnt[i] = 4'($urandom_range(9));
            rst = ($urandom_range(99) != 0);
            step();
        end
        rst = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0;
        set_cnt(1, 2, 3, 4);
        scnt[0] = 4'd7; scnt[1] = 4'd6; scnt[2] = 4'd5; scnt[3] = 4'd4;
        step(); step();
        rst = 1'b1;
        test_reset();
        test_run_stop();
        test_lap();
        test_clear();
        test_simultaneous();
        test_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
